// File: rtl/jpeg_dec_pkg.sv
// jpeg_dec_pkg: constants, FSM encoding and the amplitude extend rule shared by the
// DC and AC amplitude stages of the JPEG entropy decoder.
//   MAX_DC_SIZE  largest legal size category
//   DEF_COEF_W   default coefficient width
//   DIFF_W       width that holds any extended difference (+/-2047)
//   dc_state_e   DC amplitude decoder FSM states
//   extend_amplitude(raw, size) -> signed difference, DIFF_W bits
package jpeg_dec_pkg;

    localparam int unsigned MAX_DC_SIZE = 11;
    localparam int unsigned DEF_COEF_W  = 12;
    localparam int unsigned DIFF_W      = MAX_DC_SIZE + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StOutput  = 2'd2
    } dc_state_e;

    // A leading 1 means a positive value taken as-is; a leading 0 means a negative value
    // offset by (2^size - 1). Illegal or zero sizes give a zero difference.
    function automatic logic [DIFF_W-1:0] extend_amplitude(
        input logic [MAX_DC_SIZE-1:0] raw,
        input logic [3:0]             size
    );
        logic [DIFF_W-1:0] raw_w;
        logic [DIFF_W-1:0] ones;
        logic [DIFF_W-1:0] result;
        raw_w = {1'b0, raw};
        ones  = (DIFF_W'(1) << size) - DIFF_W'(1);
        if (size == 4'd0 || size > 4'(MAX_DC_SIZE)) begin
            result = '0;
        end else if (raw[size - 4'd1]) begin
            result = raw_w;
        end else begin
            result = raw_w - ones;
        end
        return result;
    endfunction

endpackage

// File: rtl/amplitude_extend.sv
// amplitude_extend: combinational amplitude-to-difference extension, shared by DC and AC.
//   raw_i   [10:0]        amplitude bits, right-aligned
//   size_i  [3:0]         size category
//   diff_o  [COEF_W-1:0]  signed difference, sign-extended to COEF_W
module amplitude_extend
    import jpeg_dec_pkg::*;
#(
    parameter int unsigned COEF_W = DEF_COEF_W
) (
    input  logic [MAX_DC_SIZE-1:0]   raw_i,
    input  logic [3:0]               size_i,
    output logic signed [COEF_W-1:0] diff_o
);

    logic signed [DIFF_W-1:0] diff_s;

    assign diff_s = signed'(extend_amplitude(raw_i, size_i));
    assign diff_o = COEF_W'(diff_s);

endmodule

// File: rtl/dc_amplitude_decoder.sv
// dc_amplitude_decoder: collects the DC amplitude bits for a resolved size category,
// extends them to a difference, adds the per-component predictor and presents the
// reconstructed DC coefficient over valid/ready.
//   clk, rst                  clock, synchronous active-high reset
//   size_valid/size_ready     size category handshake (size_in, comp_id)
//   bit_valid/bit_ready       serial amplitude bits, MSB first (bit_in)
//   dc_valid/dc_ready         coefficient handshake (dc_coef)
//   pred_clear                zero all predictors
//   err                       sticky illegal-size flag
module dc_amplitude_decoder
    import jpeg_dec_pkg::*;
#(
    parameter int unsigned COEF_W   = DEF_COEF_W,
    parameter int unsigned NUM_COMP = 3,
    localparam int unsigned CompW   = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     size_valid,
    input  logic [3:0]               size_in,
    input  logic [CompW-1:0]         comp_id,
    output logic                     size_ready,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    output logic                     bit_ready,
    output logic                     dc_valid,
    input  logic                     dc_ready,
    output logic signed [COEF_W-1:0] dc_coef,
    input  logic                     pred_clear,
    output logic                     err
);

    dc_state_e               state_q, state_d;
    logic [3:0]              size_q, size_d;
    logic [CompW-1:0]        comp_q, comp_d;
    logic [3:0]              count_q, count_d;
    logic [MAX_DC_SIZE-1:0]  raw_q, raw_d;
    logic [COEF_W-1:0]       dc_coef_q, dc_coef_d;
    logic                    err_q, err_d;
    logic [COEF_W-1:0]       pred_q [NUM_COMP];
    logic [COEF_W-1:0]       pred_d [NUM_COMP];

    logic [MAX_DC_SIZE-1:0]  raw_next;
    logic signed [COEF_W-1:0] diff;
    logic                    load;
    logic                    use_diff;
    logic [CompW-1:0]        comp_sel;
    logic                    comp_ok;
    logic [COEF_W-1:0]       pred_base;
    logic [COEF_W-1:0]       sum;

    assign raw_next = {raw_q[MAX_DC_SIZE-2:0], bit_in};

    // Extend the shifted-in value so the last bit's cycle can load the coefficient directly.
    amplitude_extend #(
        .COEF_W (COEF_W)
    ) u_extend (
        .raw_i  (raw_next),
        .size_i (size_q),
        .diff_o (diff)
    );

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        comp_d    = comp_q;
        count_d   = count_q;
        raw_d     = raw_q;
        err_d     = err_q;
        dc_coef_d = dc_coef_q;
        pred_d    = pred_q;
        load      = 1'b0;
        use_diff  = 1'b0;
        comp_sel  = comp_q;

        unique case (state_q)
            StIdle: begin
                if (size_valid) begin
                    size_d   = size_in;
                    comp_d   = comp_id;
                    count_d  = size_in;
                    raw_d    = '0;
                    comp_sel = comp_id;
                    if (size_in == 4'd0) begin
                        load    = 1'b1;
                        state_d = StOutput;
                    end else if (size_in > 4'(MAX_DC_SIZE)) begin
                        err_d   = 1'b1;
                        load    = 1'b1;
                        state_d = StOutput;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (bit_valid) begin
                    raw_d   = raw_next;
                    count_d = count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        load     = 1'b1;
                        use_diff = 1'b1;
                        state_d  = StOutput;
                    end
                end
            end
            StOutput: begin
                if (dc_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Out-of-range component indices read and update nothing.
        comp_ok   = 32'(comp_sel) < NUM_COMP;
        pred_base = (comp_ok && !pred_clear) ? pred_q[comp_sel] : '0;
        sum       = pred_base + (use_diff ? diff : '0);
        if (load) begin
            dc_coef_d = sum;
            if (comp_ok) begin
                pred_d[comp_sel] = sum;
            end
        end

        // Clear wins over the predictor write above.
        if (pred_clear) begin
            for (int unsigned i = 0; i < NUM_COMP; i++) begin
                pred_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            size_q    <= '0;
            comp_q    <= '0;
            count_q   <= '0;
            raw_q     <= '0;
            dc_coef_q <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_COMP; i++) begin
                pred_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            comp_q    <= comp_d;
            count_q   <= count_d;
            raw_q     <= raw_d;
            dc_coef_q <= dc_coef_d;
            err_q     <= err_d;
            pred_q    <= pred_d;
        end
    end

    assign size_ready = !rst && (state_q == StIdle);
    assign bit_ready  = !rst && (state_q == StCollect);
    assign dc_valid   = !rst && (state_q == StOutput);
    assign dc_coef    = dc_coef_q;
    assign err        = err_q;

endmodule
